foc_pi_scheduler: RTL and testbench
===================================

// Module: foc_pi_scheduler
// PURPOSE
// - Sequences the d-axis and q-axis current PI controllers of the FOC loop.
// - Latches each current sample and decimates the sample stream.
// - Issues one-cycle enables to both PI instances, then collects their delayed results.
// - Emits an aligned (Vd, Vq) pair with one valid pulse. Detects lost responses and overrun samples.
// - Sits between the Clarke/Park transform output and the inverse-Park stage.
// PARAMETERS
// - DIV      default 1   run the PI pair on every DIV-th accepted sample (1..255)
// - TIMEOUT  default 15  WAIT-state cycles allowed before a timeout (>=6; PI latency is 5)
// - VLIM     default 16'sd30000  output magnitude clamp (used only when macro is defined)
// PORTS
// - rstn        in   1    async active-low reset
// - clk         in   1    single clock
// - i_en        in   1    new current sample valid (1-cycle pulse)
// - i_id_aim    in   16s  d-axis current setpoint
// - i_iq_aim    in   16s  q-axis current setpoint
// - i_id        in   16s  measured d-axis current
// - i_iq        in   16s  measured q-axis current
// - o_d_en      out  1    enable pulse to d-axis PI
// - o_d_aim     out  16s  d-axis PI setpoint (held between issues)
// - o_d_real    out  16s  d-axis PI feedback (held between issues)
// - i_d_en      in   1    d-axis PI result valid
// - i_d_value   in   16s  d-axis PI result
// - o_q_en / o_q_aim / o_q_real / i_q_en / i_q_value   same as d-axis, for q
// - o_en        out  1    Vd/Vq pair valid (1-cycle pulse)
// - o_vd        out  16s  d-axis voltage command (held)
// - o_vq        out  16s  q-axis voltage command (held)
// - o_timeout   out  1    1-cycle pulse: a response did not arrive in time
// - o_drop_cnt  out  8    saturating count of samples dropped while busy
// BEHAVIOUR
// - Reset: state=IDLE; decim_cnt=0; wait_cnt=0; all outputs 0; got_d=got_q=0.
// - FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
// - IDLE: on i_en, latch aims/reals into o_*_aim/o_*_real.
//   - If decim_cnt==0 go to ISSUE.
//   - decim_cnt <= (decim_cnt==DIV-1) ? 0 : decim_cnt+1.
// - ISSUE: o_d_en=o_q_en=1 for exactly this cycle (same cycle for both). Clear got_d/got_q and wait_cnt. Go to WAIT.
// - WAIT: wait_cnt increments each cycle.
//   - On i_d_en, capture i_d_value into the vd holding register and set got_d. Same for q.
//   - Both flags may set in the same cycle.
//   - Once got_d&got_q (including same-cycle arrival), go to DONE.
//   - If wait_cnt==TIMEOUT-1 without both flags: pulse o_timeout, go to IDLE, do not pulse o_en.
//   - On timeout, o_vd/o_vq keep their previous values. Partial captures are discarded.
// - DONE: o_vd/o_vq update from the holding registers and o_en pulses in the same cycle. Go to IDLE.
// - Nominal latency: i_en to o_en = 8 cycles (IDLE 1 + ISSUE 1 + PI 5 + DONE 1).
// - Any i_en while not in IDLE is dropped: inputs not latched, decim_cnt unchanged.
//   - o_drop_cnt increments and saturates at 255.
// - i_d_en/i_q_en outside WAIT are ignored (stale responses).
// - Reset asserted mid-operation clears everything immediately. The PI pipelines are reset by the same rstn.
// CONFIGURATION
// - Macro FOC_PI_SCHED_VLIM_EN.
// - Defined: at DONE, o_vd and o_vq are each clamped to [-VLIM, +VLIM] (signed compare, per axis).
// - Undefined: PI results are passed through unchanged and VLIM is unused.
// TESTING
// - DIV=1, i_id_aim=0, i_id=0, i_iq_aim=1000, i_iq=0, PI stubs reply after 5 cycles with 111/222
//   -> o_en 8 cycles after i_en; o_vd=111, o_vq=222; o_timeout=0.
// - DIV=4, 12 i_en pulses spaced 20 cycles apart -> exactly 3 o_d_en/o_q_en pulses (samples 1, 5, 9).
// - Extra i_en pulses 2 and 4 cycles after an accepted one -> o_drop_cnt=2; o_en fires once, with values from the first sample.
// - q stub never replies -> o_timeout pulses TIMEOUT cycles after WAIT entry; no o_en; o_vd/o_vq unchanged.
// - Stale i_d_en in IDLE, then a normal cycle -> the stale value never reaches o_vd.
// - With FOC_PI_SCHED_VLIM_EN, VLIM=1000, stub values 5000/-5000 -> o_vd=1000, o_vq=-1000.
// - Without the macro, the same stimulus -> o_vd=5000, o_vq=-5000.
// - rstn low during WAIT -> all outputs 0 next edge; no o_en until a new i_en.

Source files
------------

// File: rtl/foc_pi_scheduler_if.sv
// Handshake bundle between the current-sample source, the d/q PI pair and the inverse-Park stage.
// The scheduler takes the slave view; the surrounding environment takes the master view.
interface foc_pi_scheduler_if;
   logic               i_en;
   logic signed [15:0] i_id_aim;
   logic signed [15:0] i_iq_aim;
   logic signed [15:0] i_id;
   logic signed [15:0] i_iq;

   logic               o_d_en;
   logic signed [15:0] o_d_aim;
   logic signed [15:0] o_d_real;
   logic               i_d_en;
   logic signed [15:0] i_d_value;

   logic               o_q_en;
   logic signed [15:0] o_q_aim;
   logic signed [15:0] o_q_real;
   logic               i_q_en;
   logic signed [15:0] i_q_value;

   logic               o_en;
   logic signed [15:0] o_vd;
   logic signed [15:0] o_vq;
   logic               o_timeout;
   logic [7:0]         o_drop_cnt;

   modport slave (
      input  i_en, i_id_aim, i_iq_aim, i_id, i_iq,
      output o_d_en, o_d_aim, o_d_real,
      input  i_d_en, i_d_value,
      output o_q_en, o_q_aim, o_q_real,
      input  i_q_en, i_q_value,
      output o_en, o_vd, o_vq, o_timeout, o_drop_cnt
   );

   modport master (
      output i_en, i_id_aim, i_iq_aim, i_id, i_iq,
      input  o_d_en, o_d_aim, o_d_real,
      output i_d_en, i_d_value,
      input  o_q_en, o_q_aim, o_q_real,
      output i_q_en, i_q_value,
      input  o_en, o_vd, o_vq, o_timeout, o_drop_cnt
   );
endinterface

// File: rtl/foc_pi_scheduler.sv
// Sequences the d/q current PI pair: latches and decimates samples, issues both PIs, aligns results.
// Define FOC_PI_SCHED_VLIM_EN to clamp each voltage command to [-VLIM, +VLIM].
module foc_pi_scheduler #(
   parameter int unsigned        DIV     = 1,
   parameter int unsigned        TIMEOUT = 15,
   parameter logic signed [15:0] VLIM    = 16'sd30000
) (
   input logic               clk,
   input logic               rstn,
   foc_pi_scheduler_if.slave bus
);

   localparam int unsigned      WaitW    = $clog2(TIMEOUT);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
   localparam logic [7:0]       DecLast  = 8'(DIV - 1);

   if (DIV < 1 || DIV > 255 || TIMEOUT < 6 || VLIM < 0) begin : g_param_check
      $error("foc_pi_scheduler: parameter out of range");
   end

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e             state_q, state_d;
   logic [7:0]         decim_q, decim_d;
   logic [WaitW-1:0]   wait_q, wait_d;
   logic               d_got_q, d_got_d;
   logic               q_got_q, q_got_d;
   logic signed [15:0] vd_hold_q, vd_hold_d;
   logic signed [15:0] vq_hold_q, vq_hold_d;
   logic signed [15:0] d_aim_q, d_aim_d;
   logic signed [15:0] d_real_q, d_real_d;
   logic signed [15:0] q_aim_q, q_aim_d;
   logic signed [15:0] q_real_q, q_real_d;
   logic signed [15:0] vd_q, vd_d;
   logic signed [15:0] vq_q, vq_d;
   logic               en_q, en_d;
   logic               timeout_q, timeout_d;
   logic [7:0]         drop_q, drop_d;
   logic               d_ok, q_ok;

`ifdef FOC_PI_SCHED_VLIM_EN
   function automatic logic signed [15:0] vlimit(input logic signed [15:0] v);
      if (v > VLIM) return VLIM;
      if (v < -VLIM) return -VLIM;
      return v;
   endfunction
`else
   function automatic logic signed [15:0] vlimit(input logic signed [15:0] v);
      return v;
   endfunction
`endif

   always_comb begin
      state_d   = state_q;
      decim_d   = decim_q;
      wait_d    = wait_q;
      d_got_d   = d_got_q;
      q_got_d   = q_got_q;
      vd_hold_d = vd_hold_q;
      vq_hold_d = vq_hold_q;
      d_aim_d   = d_aim_q;
      d_real_d  = d_real_q;
      q_aim_d   = q_aim_q;
      q_real_d  = q_real_q;
      vd_d      = vd_q;
      vq_d      = vq_q;
      en_d      = 1'b0;
      timeout_d = 1'b0;
      drop_d    = drop_q;
      // Arrivals in the current cycle count toward completion.
      d_ok      = d_got_q | bus.i_d_en;
      q_ok      = q_got_q | bus.i_q_en;

      if (bus.i_en && state_q != StIdle && drop_q != 8'hff) begin
         drop_d = drop_q + 8'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.i_en) begin
               d_aim_d  = bus.i_id_aim;
               d_real_d = bus.i_id;
               q_aim_d  = bus.i_iq_aim;
               q_real_d = bus.i_iq;
               if (decim_q == 8'd0) state_d = StIssue;
               decim_d = (decim_q == DecLast) ? 8'd0 : decim_q + 8'd1;
            end
         end
         StIssue: begin
            d_got_d = 1'b0;
            q_got_d = 1'b0;
            wait_d  = '0;
            state_d = StWait;
         end
         StWait: begin
            wait_d = wait_q + 1'b1;
            if (bus.i_d_en) begin
               vd_hold_d = bus.i_d_value;
               d_got_d   = 1'b1;
            end
            if (bus.i_q_en) begin
               vq_hold_d = bus.i_q_value;
               q_got_d   = 1'b1;
            end
            if (d_ok && q_ok) begin
               state_d = StDone;
            end else if (wait_q == WaitLast) begin
               timeout_d = 1'b1;
               state_d   = StIdle;
            end
         end
         StDone: begin
            vd_d    = vlimit(vd_hold_q);
            vq_d    = vlimit(vq_hold_q);
            en_d    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StIdle;
         decim_q   <= 8'd0;
         wait_q    <= '0;
         d_got_q   <= 1'b0;
         q_got_q   <= 1'b0;
         vd_hold_q <= '0;
         vq_hold_q <= '0;
         d_aim_q   <= '0;
         d_real_q  <= '0;
         q_aim_q   <= '0;
         q_real_q  <= '0;
         vd_q      <= '0;
         vq_q      <= '0;
         en_q      <= 1'b0;
         timeout_q <= 1'b0;
         drop_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         decim_q   <= decim_d;
         wait_q    <= wait_d;
         d_got_q   <= d_got_d;
         q_got_q   <= q_got_d;
         vd_hold_q <= vd_hold_d;
         vq_hold_q <= vq_hold_d;
         d_aim_q   <= d_aim_d;
         d_real_q  <= d_real_d;
         q_aim_q   <= q_aim_d;
         q_real_q  <= q_real_d;
         vd_q      <= vd_d;
         vq_q      <= vq_d;
         en_q      <= en_d;
         timeout_q <= timeout_d;
         drop_q    <= drop_d;
      end
   end

   // Both PI enables are decoded from the state so they share the single ISSUE cycle.
   assign bus.o_d_en     = (state_q == StIssue);
   assign bus.o_q_en     = (state_q == StIssue);
   assign bus.o_d_aim    = d_aim_q;
   assign bus.o_d_real   = d_real_q;
   assign bus.o_q_aim    = q_aim_q;
   assign bus.o_q_real   = q_real_q;
   assign bus.o_en       = en_q;
   assign bus.o_vd       = vd_q;
   assign bus.o_vq       = vq_q;
   assign bus.o_timeout  = timeout_q;
   assign bus.o_drop_cnt = drop_q;

endmodule

// File: tb/tb_foc_pi_scheduler.sv
// Bench for foc_pi_scheduler: directed scenarios plus random traffic checked against a
// transaction-level timing model; a second DIV=4 instance covers decimation.
module tb_foc_pi_scheduler;
   localparam int                 TO   = 15;
   localparam int                 DIV1 = 1;
   localparam logic signed [15:0] VL   = 16'sd1000;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   foc_pi_scheduler_if f1 ();
   foc_pi_scheduler_if f4 ();

   foc_pi_scheduler #(.DIV(DIV1), .TIMEOUT(TO), .VLIM(VL)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (f1.slave)
   );

   foc_pi_scheduler #(.DIV(4), .TIMEOUT(TO), .VLIM(VL)) dut4 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (f4.slave)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference model: event times and held values per accepted sample.
   int m_busy, m_issue_at, m_en_at, m_to_at, m_dec, m_drop;
   logic signed [15:0] m_vd, m_vq, m_pvd, m_pvq, m_da, m_dr, m_qa, m_qr;

   logic signed [15:0] s_da, s_dr, s_qa, s_qr;
   int d_dly, q_dly, d_tmr, q_tmr;
   logic signed [15:0] d_val, q_val, d_lat, q_lat;
   bit rnd_stub;

   int en_cnt = 0, to_cnt = 0, last_en_cyc = -1000, last_to_cyc = -1000;
   int t4_d, t4_q, k4 = 0, iss4_cnt = 0, q4_cnt = 0;
   int iss4 [3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic signed [15:0] lim(input logic signed [15:0] v);
`ifdef FOC_PI_SCHED_VLIM_EN
      if (v > VL) return VL;
      if (v < -VL) return -VL;
`endif
      return v;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_issue_at = -1; m_en_at = -1; m_to_at = -1; m_dec = 0; m_drop = 0;
      m_vd = '0; m_vq = '0; m_pvd = '0; m_pvq = '0;
      m_da = '0; m_dr = '0; m_qa = '0; m_qr = '0;
      d_tmr = 0; q_tmr = 0; t4_d = 0; t4_q = 0;
   endtask

   task automatic tick(input bit en, input bit stale, input bit en4);
      int s, mx;
      @(negedge clk);
      cyc++;
      if (cyc == m_en_at) begin
         m_vd = m_pvd;
         m_vq = m_pvq;
      end
      chk("o_en", 32'(f1.o_en), 32'(cyc == m_en_at));
      chk("o_timeout", 32'(f1.o_timeout), 32'(cyc == m_to_at));
      chk("o_d_en", 32'(f1.o_d_en), 32'(cyc == m_issue_at));
      chk("o_q_en", 32'(f1.o_q_en), 32'(cyc == m_issue_at));
      chk("o_vd", 32'(f1.o_vd), 32'(m_vd));
      chk("o_vq", 32'(f1.o_vq), 32'(m_vq));
      chk("o_drop_cnt", 32'(f1.o_drop_cnt), 32'(m_drop));
      chk("o_d_aim", 32'(f1.o_d_aim), 32'(m_da));
      chk("o_d_real", 32'(f1.o_d_real), 32'(m_dr));
      chk("o_q_aim", 32'(f1.o_q_aim), 32'(m_qa));
      chk("o_q_real", 32'(f1.o_q_real), 32'(m_qr));
      if (f1.o_en) begin en_cnt++; last_en_cyc = cyc; end
      if (f1.o_timeout) begin to_cnt++; last_to_cyc = cyc; end

      // PI stubs: reply d_dly/q_dly cycles after the enable; 0 means never.
      f1.i_d_en = 1'b0;
      f1.i_q_en = 1'b0;
      if (d_tmr > 0) begin
         d_tmr--;
         if (d_tmr == 0) begin f1.i_d_en = 1'b1; f1.i_d_value = d_lat; end
      end
      if (q_tmr > 0) begin
         q_tmr--;
         if (q_tmr == 0) begin f1.i_q_en = 1'b1; f1.i_q_value = q_lat; end
      end
      if (f1.o_d_en) begin d_tmr = d_dly; d_lat = d_val; end
      if (f1.o_q_en) begin q_tmr = q_dly; q_lat = q_val; end
      if (rnd_stub && (f1.o_d_en || f1.o_q_en)) begin
         d_dly = $urandom_range(0, TO + 2);
         q_dly = $urandom_range(0, TO + 2);
         d_val = 16'($urandom);
         q_val = 16'($urandom);
      end
      if (stale) begin
         f1.i_d_en = 1'b1; f1.i_d_value = 16'sh7777;
         f1.i_q_en = 1'b1; f1.i_q_value = 16'sh6666;
      end

      f1.i_en = en;
      f1.i_id_aim = s_da; f1.i_id = s_dr; f1.i_iq_aim = s_qa; f1.i_iq = s_qr;
      if (en) begin
         if (cyc >= m_busy) begin
            m_da = s_da; m_dr = s_dr; m_qa = s_qa; m_qr = s_qr;
            m_busy = cyc + 1;
            if (m_dec == 0) begin
               s = cyc + 1;
               m_issue_at = s;
               mx = (d_dly > q_dly) ? d_dly : q_dly;
               if (d_dly > 0 && q_dly > 0 && mx <= TO) begin
                  m_en_at = s + mx + 2;
                  m_pvd = lim(d_val);
                  m_pvq = lim(q_val);
                  m_busy = m_en_at;
               end else begin
                  m_to_at = s + TO + 1;
                  m_busy = m_to_at;
               end
            end
            m_dec = (m_dec == DIV1 - 1) ? 0 : m_dec + 1;
         end else if (m_drop < 255) begin
            m_drop++;
         end
      end

      // DIV=4 instance: fixed 5-cycle stubs, record which sample each issue belongs to.
      f4.i_d_en = 1'b0;
      f4.i_q_en = 1'b0;
      if (t4_d > 0) begin t4_d--; if (t4_d == 0) begin f4.i_d_en = 1'b1; f4.i_d_value = 16'sd7; end end
      if (t4_q > 0) begin t4_q--; if (t4_q == 0) begin f4.i_q_en = 1'b1; f4.i_q_value = 16'sd9; end end
      if (f4.o_d_en) begin
         t4_d = 5;
         if (iss4_cnt < 3) iss4[iss4_cnt] = k4;
         iss4_cnt++;
      end
      if (f4.o_q_en) begin t4_q = 5; q4_cnt++; end
      f4.i_en = en4;
      if (en4) k4++;
      f4.i_id_aim = 16'(k4); f4.i_id = '0; f4.i_iq_aim = '0; f4.i_iq = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      cyc++;
      rstn = 1'b0;
      #1;
      chk("rst_o_en", 32'(f1.o_en), 32'd0);
      chk("rst_o_timeout", 32'(f1.o_timeout), 32'd0);
      chk("rst_o_d_en", 32'(f1.o_d_en), 32'd0);
      chk("rst_o_q_en", 32'(f1.o_q_en), 32'd0);
      chk("rst_o_vd", 32'(f1.o_vd), 32'd0);
      chk("rst_o_vq", 32'(f1.o_vq), 32'd0);
      chk("rst_o_drop_cnt", 32'(f1.o_drop_cnt), 32'd0);
      chk("rst_o_d_aim", 32'(f1.o_d_aim), 32'd0);
      chk("rst_o_q_real", 32'(f1.o_q_real), 32'd0);
      model_reset();
      f1.i_en = 1'b0; f1.i_d_en = 1'b0; f1.i_q_en = 1'b0;
      f4.i_en = 1'b0; f4.i_d_en = 1'b0; f4.i_q_en = 1'b0;
      repeat (2) begin @(negedge clk); cyc++; end
      rstn = 1'b1;
   endtask

   initial begin
      int t0;
      bit en_r;
      f1.i_en = 1'b0; f1.i_d_en = 1'b0; f1.i_q_en = 1'b0; f1.i_d_value = '0; f1.i_q_value = '0;
      f4.i_en = 1'b0; f4.i_d_en = 1'b0; f4.i_q_en = 1'b0; f4.i_d_value = '0; f4.i_q_value = '0;
      s_da = '0; s_dr = '0; s_qa = '0; s_qr = '0;
      d_dly = 5; q_dly = 5; d_val = '0; q_val = '0; d_lat = '0; q_lat = '0;
      rnd_stub = 0;
      model_reset();
      do_reset();
      repeat (3) tick(0, 0, 0);

      // Nominal transaction: 8-cycle latency, stub values pass through.
      d_val = 16'sd111; q_val = 16'sd222;
      s_da = 16'sd0; s_dr = 16'sd0; s_qa = 16'sd1000; s_qr = 16'sd0;
      tick(1, 0, 0);
      t0 = cyc;
      repeat (12) tick(0, 0, 0);
      chk("latency", 32'(last_en_cyc - t0), 32'd8);
      chk("nom_vd", 32'(f1.o_vd), 32'(111));
      chk("nom_vq", 32'(f1.o_vq), 32'(222));
      chk("nom_no_timeout", 32'(to_cnt), 32'd0);

      // Samples arriving 2 and 4 cycles after an accepted one are dropped.
      d_val = -16'sd300; q_val = 16'sd400;
      s_da = 16'sd11; s_dr = 16'sd12; s_qa = 16'sd13; s_qr = 16'sd14;
      tick(1, 0, 0);
      s_da = 16'sd99; s_dr = 16'sd98; s_qa = 16'sd97; s_qr = 16'sd96;
      tick(0, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(1, 0, 0);
      repeat (12) tick(0, 0, 0);
      chk("drop_cnt", 32'(f1.o_drop_cnt), 32'd2);
      chk("drop_en_once", 32'(en_cnt), 32'd2);
      chk("drop_vd_first", 32'(f1.o_vd), 32'(-300));
      chk("drop_aim_first", 32'(f1.o_d_aim), 32'(11));

      // q never answers: timeout TO cycles after WAIT entry, outputs hold.
      d_val = 16'sd777; q_dly = 0;
      tick(1, 0, 0);
      t0 = cyc;
      repeat (TO + 5) tick(0, 0, 0);
      chk("timeout_lat", 32'(last_to_cyc - t0), 32'(TO + 2));
      chk("timeout_vd_held", 32'(f1.o_vd), 32'(-300));
      chk("timeout_vq_held", 32'(f1.o_vq), 32'(400));
      chk("timeout_no_en", 32'(en_cnt), 32'd2);

      // Stale responses in IDLE never reach the outputs.
      d_dly = 5; q_dly = 5; d_val = 16'sd333; q_val = 16'sd444;
      tick(0, 1, 0); tick(0, 0, 0);
      tick(1, 0, 0);
      repeat (10) tick(0, 0, 0);
      chk("stale_vd", 32'(f1.o_vd), 32'(333));
      chk("stale_vq", 32'(f1.o_vq), 32'(444));

      // Clamp boundary.
      d_val = 16'sd5000; q_val = -16'sd5000;
      tick(1, 0, 0);
      repeat (10) tick(0, 0, 0);
`ifdef FOC_PI_SCHED_VLIM_EN
      chk("clamp_vd", 32'(f1.o_vd), 32'(1000));
      chk("clamp_vq", 32'(f1.o_vq), 32'(-1000));
`else
      chk("pass_vd", 32'(f1.o_vd), 32'(5000));
      chk("pass_vq", 32'(f1.o_vq), 32'(-5000));
`endif

      // Decimation by 4: samples 1, 5 and 9 of 12 are issued.
      for (int k = 0; k < 12; k++) begin
         tick(0, 0, 1);
         repeat (19) tick(0, 0, 0);
      end
      chk("div4_d_issues", 32'(iss4_cnt), 32'd3);
      chk("div4_q_issues", 32'(q4_cnt), 32'd3);
      chk("div4_first", 32'(iss4[0]), 32'd1);
      chk("div4_second", 32'(iss4[1]), 32'd5);
      chk("div4_third", 32'(iss4[2]), 32'd9);

      // Random traffic against the model.
      rnd_stub = 1;
      d_dly = $urandom_range(1, TO); q_dly = $urandom_range(1, TO);
      d_val = 16'($urandom); q_val = 16'($urandom);
      for (int n = 0; n < 600; n++) begin
         en_r = ($urandom_range(0, 3) == 0);
         s_da = 16'($urandom); s_dr = 16'($urandom);
         s_qa = 16'($urandom); s_qr = 16'($urandom);
         tick(en_r, 0, 0);
      end
      rnd_stub = 0;
      repeat (TO + 25) tick(0, 0, 0);

      // Reset in the middle of WAIT.
      d_dly = 5; q_dly = 5; d_val = 16'sd1; q_val = 16'sd2;
      tick(1, 0, 0);
      repeat (3) tick(0, 0, 0);
      do_reset();
      repeat (12) tick(0, 0, 0);
      chk("post_rst_vd", 32'(f1.o_vd), 32'd0);
      tick(1, 0, 0);
      repeat (10) tick(0, 0, 0);
      chk("post_rst_new_vd", 32'(f1.o_vd), 32'(1));
      chk("post_rst_new_vq", 32'(f1.o_vq), 32'(2));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
